tick_timer_bank: RTL and testbench
==================================

Name: tick_timer_bank

Overview:
- Bank of N_CH independent, runtime-programmable tick generators. Each channel outputs one-cycle strobes at a programmed period in clk cycles.
- Replaces per-rate fixed-constant timers and the runtime-divide timer. Game logic (ball speed, paddle repeat, debounce, display refresh) shares one bank.
- Each channel supports periodic or one-shot mode, start/stop control, a global pause and sticky done flags.

Parameters:
- N_CH, 4, number of channels (1..16).
- CNT_W, 26, period/counter width; 50,000,000 (1 s at 50 MHz) must fit.
- RESET_PERIOD, 50000000, period loaded into every channel at reset (truncated to CNT_W).
- CH_W (localparam), max(1, clog2(N_CH)), channel index width.

Ports:
- clk  in  1  system clock, 50 MHz.
- resetn  in  1  reset, synchronous, active-low.
- enable  in  1  global count enable; low freezes every channel.
- cfg_we  in  1  config write strobe.
- cfg_ch  in  CH_W  channel index for config write.
- cfg_period  in  CNT_W  period in clk cycles; 0 is invalid.
- cfg_oneshot  in  1  1 = one-shot, 0 = periodic.
- start  in  N_CH  per-channel start/restart pulse.
- stop  in  N_CH  per-channel stop pulse.
- done_clr  in  N_CH  per-channel clear of the done flag.
- rd_ch  in  CH_W  channel selected for count readback.
- tick  out  N_CH  registered one-cycle expiry strobe.
- running  out  N_CH  channel in RUN state.
- done  out  N_CH  sticky: a one-shot channel has expired.
- rd_count  out  CNT_W  combinational: current count of channel rd_ch (0 if rd_ch >= N_CH).

Behaviour:
- Reset values (resetn low at a clk edge):
  - all channels IDLE; count = 0; tick = 0; running = 0; done = 0.
  - period_reg = RESET_PERIOD; mode = periodic.
  - Reset mid-operation aborts all channels immediately.
- Config:
  - On cfg_we, period_reg[cfg_ch] and mode[cfg_ch] are written at the edge. cfg_ch >= N_CH: write ignored.
  - A running channel keeps its current count. The new period applies at the next reload or start.
- Per-channel FSM, 2 states: IDLE, RUN.
  - IDLE + start, period_reg != 0: count <= period_reg-1; -> RUN; done <= 0.
  - IDLE + start, period_reg == 0: ignored; stays IDLE.
  - RUN + start: restart, reloading count <= period_reg-1 (or -> IDLE if period_reg == 0); done <= 0.
  - stop (any state): -> IDLE, count held, tick <= 0.
  - stop and start in the same cycle: stop wins.
- RUN with enable = 1, at each edge:
  - count != 0: count <= count-1; tick <= 0.
  - count == 0: tick <= 1.
    - periodic: count <= period_reg-1.
    - one-shot: -> IDLE; done <= 1.
- Timing:
  - First tick is high in the cycle after the P-th enabled edge following the start edge.
  - Successive ticks are exactly P enabled cycles apart.
  - P = 1: tick held high every enabled cycle.
- enable = 0: all counts frozen, tick forced 0, state unchanged. start/stop/config still act.
- done:
  - set only by one-shot expiry.
  - cleared by done_clr or start.
  - done_clr and expiry in the same cycle: set wins.
- Arithmetic: unsigned CNT_W, no wrap. The count never decrements below 0.
- Channels are fully independent; simultaneous events on different channels are all honoured.

Test Plan:
- Periodic P=4 on ch0, enable=1, start at edge 0 -> tick[0] high after edges 4, 8, 12 only; running[0]=1 throughout.
- One-shot P=3 on ch1 -> single tick after edge 3; then running[1]=0 and done[1]=1. done_clr[1] -> done[1]=0 next cycle.
- Pause: ch0 P=4, enable low for 2 cycles after edge 2 -> first tick after edge 6. rd_count reads 1 during the pause.
- Reprogram: ch2 running P=10, cfg write P=5 at edge 3 -> ticks after edges 10, 15, 20. Start and stop together on ch2 -> IDLE, no further ticks.
- Boundaries: period 0 + start -> stays IDLE, no tick. P=1 -> tick high every cycle. cfg_ch=5 with N_CH=4 -> no channel changes.
- Reset mid-run: resetn low at edge 7 -> all outputs 0 next cycle. Restart ch0 without reconfig -> first tick after 50,000,000 edges (RESET_PERIOD); use the parameter override RESET_PERIOD=8 in sim.

Source files
------------

// File: rtl/tick_timer_bank_if.sv
// Purpose: control/status bundle between a tick_timer_bank and its user.
// Latency: n/a (wiring only).
// Backpressure: none; every strobe is sampled on the clk edge it is presented at.
// Ports: enable, cfg_* (config write), start/stop/done_clr (per-channel pulses),
//        rd_ch (count readback select) from master; tick/running/done/rd_count from slave.
interface tick_timer_bank_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 26
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic             enable;
  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_period;
  logic             cfg_oneshot;
  logic [N_CH-1:0]  start;
  logic [N_CH-1:0]  stop;
  logic [N_CH-1:0]  done_clr;
  logic [CH_W-1:0]  rd_ch;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  running;
  logic [N_CH-1:0]  done;
  logic [CNT_W-1:0] rd_count;

  modport master (
    output enable, cfg_we, cfg_ch, cfg_period, cfg_oneshot,
    output start, stop, done_clr, rd_ch,
    input  tick, running, done, rd_count
  );

  modport slave (
    input  enable, cfg_we, cfg_ch, cfg_period, cfg_oneshot,
    input  start, stop, done_clr, rd_ch,
    output tick, running, done, rd_count
  );
endinterface

// File: rtl/tick_timer_bank.sv
// Purpose: bank of N_CH programmable periodic/one-shot tick generators.
// Latency: first tick registered one cycle after the P-th enabled edge following start.
// Backpressure: none; enable low freezes all channels, control strobes still act.
// Ports: clk, resetn (sync, active-low), bus (slave side of tick_timer_bank_if).
module tick_timer_bank #(
  parameter int          N_CH         = 4,
  parameter int          CNT_W        = 26,
  parameter int unsigned RESET_PERIOD = 50000000
) (
  input logic              clk,
  input logic              resetn,
  tick_timer_bank_if.slave bus
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           r_state  [N_CH];
  logic [CNT_W-1:0] r_count  [N_CH];
  logic [CNT_W-1:0] r_period [N_CH];
  logic [N_CH-1:0]  r_oneshot;
  logic [N_CH-1:0]  r_tick;
  logic [N_CH-1:0]  r_done;
  logic [N_CH-1:0]  w_running;
  logic [CNT_W-1:0] w_rd_count;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < N_CH; i++) begin
        r_state[i]  <= IDLE;
        r_count[i]  <= '0;
        r_period[i] <= CNT_W'(RESET_PERIOD);
      end
      r_oneshot <= '0;
      r_tick    <= '0;
      r_done    <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        // Later assignments below override these defaults, which gives the
        // required priorities: stop over start, expiry set over done_clr.
        r_tick[i] <= 1'b0;
        if (bus.done_clr[i]) r_done[i] <= 1'b0;

        if (bus.stop[i]) begin
          r_state[i] <= IDLE;
        end else if (bus.start[i]) begin
          if (r_period[i] != '0) begin
            r_count[i] <= r_period[i] - CNT_W'(1);
            r_state[i] <= RUN;
            r_done[i]  <= 1'b0;
          end else if (r_state[i] == RUN) begin
            r_state[i] <= IDLE;
            r_done[i]  <= 1'b0;
          end
        end else if (r_state[i] == RUN && bus.enable) begin
          if (r_count[i] != '0) begin
            r_count[i] <= r_count[i] - CNT_W'(1);
          end else begin
            r_tick[i] <= 1'b1;
            if (r_oneshot[i]) begin
              r_state[i] <= IDLE;
              r_done[i]  <= 1'b1;
            end else if (r_period[i] != '0) begin
              r_count[i] <= r_period[i] - CNT_W'(1);
            end else begin
              // Period reprogrammed to 0 while running: reloading would
              // wrap the counter, so the channel parks instead.
              r_state[i] <= IDLE;
            end
          end
        end

        // Config lands at this edge; the start/reload above used the old period.
        if (bus.cfg_we && bus.cfg_ch == CH_W'(i)) begin
          r_period[i]  <= bus.cfg_period;
          r_oneshot[i] <= bus.cfg_oneshot;
        end
      end
    end
  end

  always_comb begin
    w_running  = '0;
    w_rd_count = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_running[i] = (r_state[i] == RUN);
      // Out-of-range rd_ch matches no channel and reads back 0.
      if (bus.rd_ch == CH_W'(i)) w_rd_count = r_count[i];
    end
  end

  assign bus.tick     = r_tick;
  assign bus.running  = w_running;
  assign bus.done     = r_done;
  assign bus.rd_count = w_rd_count;
endmodule

// File: tb/tb_tick_timer_bank.sv
module tb_tick_timer_bank;
  localparam int N   = 5;
  localparam int CW  = 26;
  localparam int RP  = 8;
  localparam int CHW = 3;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  tick_timer_bank_if #(.N_CH(N), .CNT_W(CW)) tb_if ();

  tick_timer_bank #(.N_CH(N), .CNT_W(CW), .RESET_PERIOD(RP)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (tb_if.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: each channel tracks how many enabled edges remain until
  // its next expiry (m_left); the visible count is always m_left-1.
  bit m_run  [N];
  int m_left [N];
  int m_per  [N];
  bit m_one  [N];
  bit m_done [N];
  bit m_tick [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_edge();
    if (!resetn) begin
      for (int i = 0; i < N; i++) begin
        m_run[i] = 0; m_left[i] = 1; m_per[i] = RP; m_one[i] = 0;
        m_done[i] = 0; m_tick[i] = 0;
      end
      return;
    end
    for (int i = 0; i < N; i++) begin
      int p;
      p = m_per[i];
      m_tick[i] = 0;
      if (tb_if.done_clr[i]) m_done[i] = 0;
      if (tb_if.stop[i]) begin
        m_run[i] = 0;
      end else if (tb_if.start[i]) begin
        if (p != 0) begin
          m_run[i] = 1; m_left[i] = p; m_done[i] = 0;
        end else if (m_run[i]) begin
          m_run[i] = 0; m_done[i] = 0;
        end
      end else if (m_run[i] && tb_if.enable) begin
        m_left[i]--;
        if (m_left[i] == 0) begin
          m_tick[i] = 1;
          if (m_one[i]) begin
            m_run[i] = 0; m_done[i] = 1; m_left[i] = 1;
          end else if (p != 0) begin
            m_left[i] = p;
          end else begin
            m_run[i] = 0; m_left[i] = 1;
          end
        end
      end
      if (tb_if.cfg_we && int'(tb_if.cfg_ch) == i) begin
        m_per[i] = int'(tb_if.cfg_period);
        m_one[i] = tb_if.cfg_oneshot;
      end
    end
  endfunction

  task automatic step();
    logic [N-1:0]  e_tick, e_run, e_done;
    logic [CW-1:0] e_cnt;
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < N; i++) begin
      e_tick[i] = m_tick[i]; e_run[i] = m_run[i]; e_done[i] = m_done[i];
    end
    e_cnt = (int'(tb_if.rd_ch) < N) ? CW'(m_left[tb_if.rd_ch] - 1) : '0;
    chk("tick",     32'(tb_if.tick),     32'(e_tick));
    chk("running",  32'(tb_if.running),  32'(e_run));
    chk("done",     32'(tb_if.done),     32'(e_done));
    chk("rd_count", 32'(tb_if.rd_count), 32'(e_cnt));
    tb_if.start = '0; tb_if.stop = '0; tb_if.done_clr = '0; tb_if.cfg_we = 1'b0;
  endtask

  task automatic cfg(input int ch, input int per, input bit one);
    tb_if.cfg_we = 1'b1; tb_if.cfg_ch = CHW'(ch);
    tb_if.cfg_period = CW'(per); tb_if.cfg_oneshot = one;
  endtask

  initial begin
    resetn = 1'b0;
    tb_if.enable = 1'b0; tb_if.cfg_we = 1'b0; tb_if.cfg_ch = '0;
    tb_if.cfg_period = '0; tb_if.cfg_oneshot = 1'b0; tb_if.start = '0;
    tb_if.stop = '0; tb_if.done_clr = '0; tb_if.rd_ch = '0;
    #1;
    step(); step();
    chk("reset_outs", 32'({tb_if.tick, tb_if.running, tb_if.done}), 32'd0);
    resetn = 1'b1;
    tb_if.enable = 1'b1;

    // Periodic P=4 on ch0
    cfg(0, 4, 0); step();
    tb_if.start[0] = 1'b1; step();
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("t1_tick0", 32'(tb_if.tick[0]), 32'((k % 4) == 0));
      chk("t1_run0",  32'(tb_if.running[0]), 32'd1);
    end
    tb_if.stop[0] = 1'b1; step();

    // One-shot P=3 on ch1
    cfg(1, 3, 1); step();
    tb_if.start[1] = 1'b1; step();
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("t2_tick1", 32'(tb_if.tick[1]), 32'(k == 3));
    end
    chk("t2_run1",  32'(tb_if.running[1]), 32'd0);
    chk("t2_done1", 32'(tb_if.done[1]), 32'd1);
    tb_if.done_clr[1] = 1'b1; step();
    chk("t2_clr1", 32'(tb_if.done[1]), 32'd0);

    // Pause: ch0 P=4, enable low over edges 3 and 4
    tb_if.rd_ch = '0;
    tb_if.start[0] = 1'b1; step();
    step(); step();
    tb_if.enable = 1'b0;
    step(); chk("t3_pcnt", 32'(tb_if.rd_count), 32'd1);
    step(); chk("t3_ptick", 32'(tb_if.tick[0]), 32'd0);
    tb_if.enable = 1'b1;
    step(); chk("t3_e5", 32'(tb_if.tick[0]), 32'd0);
    step(); chk("t3_e6", 32'(tb_if.tick[0]), 32'd1);
    tb_if.stop[0] = 1'b1; step();

    // Reprogram ch2 mid-run
    cfg(2, 10, 0); step();
    tb_if.start[2] = 1'b1; step();
    for (int k = 1; k <= 20; k++) begin
      if (k == 3) cfg(2, 5, 0);
      step();
      chk("t4_tick2", 32'(tb_if.tick[2]), 32'(k == 10 || k == 15 || k == 20));
    end
    tb_if.start[2] = 1'b1; tb_if.stop[2] = 1'b1; step();
    for (int k = 0; k < 8; k++) begin
      step();
      chk("t4_idle2", 32'({tb_if.tick[2], tb_if.running[2]}), 32'd0);
    end

    // Boundaries: period 0, period 1, out-of-range channel
    cfg(3, 0, 0); step();
    tb_if.start[3] = 1'b1; step();
    chk("t5_p0run", 32'(tb_if.running[3]), 32'd0);
    cfg(3, 1, 0); step();
    tb_if.start[3] = 1'b1; step();
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t5_p1tick", 32'(tb_if.tick[3]), 32'd1);
    end
    tb_if.stop[3] = 1'b1; step();
    cfg(5, 2, 1); step();
    cfg(7, 2, 1); step();
    tb_if.rd_ch = CHW'(6); step();
    chk("t5_rdoob", 32'(tb_if.rd_count), 32'd0);
    tb_if.rd_ch = '0;
    tb_if.start = '1; step();
    for (int k = 0; k < 12; k++) step();
    tb_if.stop = '1; step();

    // Reset mid-run, then restart ch0 with the reset period
    tb_if.start[0] = 1'b1; step();
    for (int k = 1; k <= 6; k++) step();
    resetn = 1'b0; step();
    chk("t6_rst", 32'({tb_if.tick, tb_if.running, tb_if.done}), 32'd0);
    resetn = 1'b1;
    tb_if.start[0] = 1'b1; step();
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("t6_tick0", 32'(tb_if.tick[0]), 32'(k == RP));
    end

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      resetn = ($urandom_range(0, 199) != 0);
      tb_if.enable = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 5) == 0) cfg($urandom_range(0, 7), $urandom_range(0, 12), 1'($urandom_range(0, 1)));
      for (int i = 0; i < N; i++) begin
        tb_if.start[i]    = ($urandom_range(0, 9) == 0);
        tb_if.stop[i]     = ($urandom_range(0, 19) == 0);
        tb_if.done_clr[i] = ($urandom_range(0, 9) == 0);
      end
      tb_if.rd_ch = CHW'($urandom_range(0, 7));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
